mac_decoder_lanes: RTL and testbench

//  Multi-lane, 2-stage pipelined operand decoder placed in front of the MAC array.

---
 rtl/mac_decoder_lanes.sv | 222 ++++++++++++++++++++++
 tb/tb_mac_decoder_lanes.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_decoder_lanes.sv
// Multi-lane, two-stage operand decoder in front of the MAC array.
// Stage 1 splits fields and classifies each lane; stage 2 normalises to unbiased exponent plus hidden-bit mantissa.
package tx_pkg;
  typedef enum logic [1:0] {
    FP16 = 2'd0,
    FP8  = 2'd1,
    INT9 = 2'd2
  } mac_datatype;
endpackage

module mac_decoder_lanes
  import tx_pkg::*;
#(
  parameter int N_LANE    = 4,
  parameter bit FLUSH_SUB = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  mac_datatype           i_datatype,
  input  logic [N_LANE*16-1:0]  i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [N_LANE-1:0]     o_iszero,
  output logic [N_LANE-1:0]     o_isinf,
  output logic [N_LANE-1:0]     o_isnan,
  output logic [N_LANE-1:0]     o_sign,
  output logic [N_LANE*7-1:0]   o_exp,
  output logic [N_LANE*11-1:0]  o_mant
);

  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_SUB  = 3'd1;
  localparam logic [2:0] CLS_NORM = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_NAN  = 3'd4;

  // Handshake: a beat transfers on valid & ready at either port. Stage 1 drains into
  // stage 2 whenever stage 2 is empty or its beat is taken this cycle, so o_ready
  // depends combinationally on i_ready and throughput stays at one beat per cycle.
  logic s2_adv, s1_mv, accept;

  logic                      s1_valid_q, s1_valid_d;
  mac_datatype               s1_dt_q, s1_dt_d;
  logic [N_LANE-1:0]         s1_sign_q, s1_sign_d;
  logic [N_LANE-1:0][4:0]    s1_e_q, s1_e_d;
  logic [N_LANE-1:0][9:0]    s1_m_q, s1_m_d;
  logic [N_LANE-1:0][2:0]    s1_cls_q, s1_cls_d;

  logic                      s2_valid_q, s2_valid_d;
  logic [N_LANE-1:0]         s2_iszero_q, s2_iszero_d;
  logic [N_LANE-1:0]         s2_isinf_q, s2_isinf_d;
  logic [N_LANE-1:0]         s2_isnan_q, s2_isnan_d;
  logic [N_LANE-1:0]         s2_sign_q, s2_sign_d;
  logic [N_LANE-1:0][6:0]    s2_exp_q, s2_exp_d;
  logic [N_LANE-1:0][10:0]   s2_mant_q, s2_mant_d;

  logic [3:0]  sub_sh;
  logic [10:0] sub_nm;
  logic [3:0]  sub_nm4;

  function automatic logic [3:0] lzc10(input logic [9:0] v);
    logic [3:0] n;
    n = 4'd10;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) n = 4'(9 - i);
    end
    return n;
  endfunction

  function automatic logic [2:0] classify(input mac_datatype dt, input logic [4:0] e,
                                          input logic [9:0] m);
    logic [2:0] c, sub_cls;
    sub_cls = FLUSH_SUB ? CLS_ZERO : CLS_SUB;
    case (dt)
      FP16: begin
        if (e == 5'd0)       c = (m == 10'd0) ? CLS_ZERO : sub_cls;
        else if (e == 5'd31) c = (m == 10'd0) ? CLS_INF : CLS_NAN;
        else                 c = CLS_NORM;
      end
      FP8: begin
        if (e == 5'd0)                       c = (m == 10'd0) ? CLS_ZERO : sub_cls;
        else if (e == 5'd15 && m == 10'd7)   c = CLS_NAN;
        else                                 c = CLS_NORM;
      end
      default: c = (m == 10'd0) ? CLS_ZERO : CLS_NORM;
    endcase
    return c;
  endfunction

  assign s2_adv  = ~s2_valid_q | i_ready;
  assign s1_mv   = s1_valid_q & s2_adv;
  assign o_ready = ~s1_valid_q | s2_adv;
  assign accept  = i_valid & o_ready;

  always_comb begin
    s1_valid_d = accept | (s1_valid_q & ~s2_adv);
    s1_dt_d    = s1_dt_q;
    s1_sign_d  = s1_sign_q;
    s1_e_d     = s1_e_q;
    s1_m_d     = s1_m_q;
    s1_cls_d   = s1_cls_q;
    if (accept) begin
      s1_dt_d = i_datatype;
      for (int k = 0; k < N_LANE; k++) begin
        case (i_datatype)
          FP16: begin
            s1_sign_d[k] = i_data[16*k+15];
            s1_e_d[k]    = i_data[16*k+10 +: 5];
            s1_m_d[k]    = i_data[16*k +: 10];
          end
          FP8: begin
            s1_sign_d[k] = i_data[16*k+7];
            s1_e_d[k]    = {1'b0, i_data[16*k+3 +: 4]};
            s1_m_d[k]    = {7'b0, i_data[16*k +: 3]};
          end
          default: begin
            s1_sign_d[k] = i_data[16*k+8];
            s1_e_d[k]    = 5'd0;
            s1_m_d[k]    = {1'b0, i_data[16*k +: 9]};
          end
        endcase
        s1_cls_d[k] = classify(i_datatype, s1_e_d[k], s1_m_d[k]);
      end
    end
  end

  always_comb begin
    s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
    s2_iszero_d = s2_iszero_q;
    s2_isinf_d  = s2_isinf_q;
    s2_isnan_d  = s2_isnan_q;
    s2_sign_d   = s2_sign_q;
    s2_exp_d    = s2_exp_q;
    s2_mant_d   = s2_mant_q;
    sub_sh      = 4'd0;
    sub_nm      = 11'd0;
    sub_nm4     = 4'd0;
    if (s1_mv) begin
      for (int k = 0; k < N_LANE; k++) begin
        s2_iszero_d[k] = 1'b0;
        s2_isinf_d[k]  = 1'b0;
        s2_isnan_d[k]  = 1'b0;
        s2_sign_d[k]   = s1_sign_q[k];
        s2_exp_d[k]    = 7'd0;
        s2_mant_d[k]   = 11'd0;
        case (s1_cls_q[k])
          CLS_ZERO: s2_iszero_d[k] = 1'b1;
          CLS_INF:  s2_isinf_d[k]  = 1'b1;
          CLS_NAN:  s2_isnan_d[k]  = 1'b1;
          CLS_SUB: begin
            // Shift past the leading one so it lands in the hidden-bit position.
            if (s1_dt_q == FP8) begin
              sub_sh        = lzc10({s1_m_q[k][2:0], 7'd0}) + 4'd1;
              sub_nm4       = {1'b1, s1_m_q[k][2:0]} << sub_sh;
              s2_mant_d[k]  = {7'd0, sub_nm4};
              s2_exp_d[k]   = 7'd0 - 7'd6 - {3'd0, sub_sh};
            end else begin
              sub_sh        = lzc10(s1_m_q[k]) + 4'd1;
              sub_nm        = {1'b1, s1_m_q[k]} << sub_sh;
              s2_mant_d[k]  = sub_nm;
              s2_exp_d[k]   = 7'd0 - 7'd14 - {3'd0, sub_sh};
            end
          end
          default: begin
            if (s1_dt_q == FP16) begin
              s2_exp_d[k]  = {2'd0, s1_e_q[k]} - 7'd15;
              s2_mant_d[k] = {1'b1, s1_m_q[k]};
            end else if (s1_dt_q == FP8) begin
              s2_exp_d[k]  = {2'd0, s1_e_q[k]} - 7'd7;
              s2_mant_d[k] = {7'd0, 1'b1, s1_m_q[k][2:0]};
            end else begin
              s2_mant_d[k] = {1'b0, s1_m_q[k]};
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q  <= 1'b0;
      s1_dt_q     <= FP16;
      s1_sign_q   <= '0;
      s1_e_q      <= '0;
      s1_m_q      <= '0;
      s1_cls_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_iszero_q <= '0;
      s2_isinf_q  <= '0;
      s2_isnan_q  <= '0;
      s2_sign_q   <= '0;
      s2_exp_q    <= '0;
      s2_mant_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_dt_q     <= s1_dt_d;
      s1_sign_q   <= s1_sign_d;
      s1_e_q      <= s1_e_d;
      s1_m_q      <= s1_m_d;
      s1_cls_q    <= s1_cls_d;
      s2_valid_q  <= s2_valid_d;
      s2_iszero_q <= s2_iszero_d;
      s2_isinf_q  <= s2_isinf_d;
      s2_isnan_q  <= s2_isnan_d;
      s2_sign_q   <= s2_sign_d;
      s2_exp_q    <= s2_exp_d;
      s2_mant_q   <= s2_mant_d;
    end
  end

  assign o_valid  = s2_valid_q;
  assign o_iszero = s2_iszero_q;
  assign o_isinf  = s2_isinf_q;
  assign o_isnan  = s2_isnan_q;
  assign o_sign   = s2_sign_q;
  assign o_exp    = s2_exp_q;
  assign o_mant   = s2_mant_q;

endmodule

// File: tb/tb_mac_decoder_lanes.sv
// Bench for mac_decoder_lanes: table of hand-decoded beats checked through an expected queue,
// plus latency, back-pressure, subnormal-flush and reset-while-full sequences.
module tb_mac_decoder_lanes;
  import tx_pkg::*;

  typedef struct {
    mac_datatype  dt;
    logic [63:0]  data;
    logic [87:0]  exp;
  } vec_t;

  logic        clk, rst, i_valid, i_ready;
  mac_datatype i_datatype;
  logic [63:0] i_data;
  logic        o_ready, o_valid, f_ready, f_valid;
  logic [3:0]  o_iszero, o_isinf, o_isnan, o_sign;
  logic [3:0]  f_iszero, f_isinf, f_isnan, f_sign;
  logic [27:0] o_exp, f_exp;
  logic [43:0] o_mant, f_mant;
  logic [87:0] out_main, out_f, cur_exp, held;
  logic [87:0] exp_q[$];
  vec_t        vecs[9];
  int          checks, errors, rdy_mode, cyc;
  logic        stalled;

  mac_decoder_lanes #(.N_LANE(4), .FLUSH_SUB(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_datatype(i_datatype), .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_iszero(o_iszero), .o_isinf(o_isinf), .o_isnan(o_isnan), .o_sign(o_sign),
    .o_exp(o_exp), .o_mant(o_mant)
  );

  mac_decoder_lanes #(.N_LANE(4), .FLUSH_SUB(1'b1)) dut_f (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(f_ready),
    .i_datatype(i_datatype), .i_data(i_data), .o_valid(f_valid), .i_ready(i_ready),
    .o_iszero(f_iszero), .o_isinf(f_isinf), .o_isnan(f_isnan), .o_sign(f_sign),
    .o_exp(f_exp), .o_mant(f_mant)
  );

  assign out_main = {o_iszero, o_isinf, o_isnan, o_sign, o_exp, o_mant};
  assign out_f    = {f_iszero, f_isinf, f_isnan, f_sign, f_exp, f_mant};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
    $fatal(1);
  end

  function automatic logic [87:0] mk_exp(logic [3:0] z, logic [3:0] inf, logic [3:0] nan,
                                         logic [3:0] s, int e0, int e1, int e2, int e3,
                                         logic [10:0] m0, logic [10:0] m1,
                                         logic [10:0] m2, logic [10:0] m3);
    return {z, inf, nan, s, 7'(e3), 7'(e2), 7'(e1), 7'(e0), m3, m2, m1, m0};
  endfunction

  function automatic vec_t mk_vec(mac_datatype dt, logic [15:0] d0, logic [15:0] d1,
                                  logic [15:0] d2, logic [15:0] d3, logic [87:0] e);
    vec_t v;
    v.dt   = dt;
    v.data = {d3, d2, d1, d0};
    v.exp  = e;
    return v;
  endfunction

  task automatic check(string name, logic [95:0] act, logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // driver tasks
  task automatic send_beat(int idx);
    int n;
    @(posedge clk);
    #1;
    i_valid    = 1'b1;
    i_datatype = vecs[idx].dt;
    i_data     = vecs[idx].data;
    cur_exp    = vecs[idx].exp;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_ready && n < 50);
    if (!o_ready) check("send_timeout", 96'(o_ready), 96'd1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 96'(exp_q.size()), 96'd0);
  endtask

  initial begin
    i_ready = 1'b1;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: i_ready = 1'b1;
        1: i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        2: i_ready = 1'($urandom_range(0, 1));
        default: i_ready = 1'b0;
      endcase
      cyc++;
    end
  end

  // scoreboard: pop on output handshake, push on input handshake, watch o_ready and stalls
  initial begin
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        stalled = 1'b0;
      end else begin
        check("o_ready", 96'(o_ready), 96'(!(exp_q.size() == 2 && !i_ready)));
        if (stalled) check("stall_hold", {7'd0, o_valid, out_main}, {7'd0, 1'b1, held});
        stalled = o_valid && !i_ready;
        held    = out_main;
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) check("unexpected_beat", 96'(o_valid), 96'd0);
          else check("beat", 96'(out_main), 96'(exp_q.pop_front()));
        end
        if (i_valid && o_ready) exp_q.push_back(cur_exp);
      end
    end
  end

  initial begin
    checks = 0; errors = 0; rdy_mode = 0;
    rst = 1'b1; i_valid = 1'b0; i_datatype = FP16; i_data = '0; cur_exp = '0; held = '0;

    vecs[0] = mk_vec(FP16, 16'h3C00, 16'h0001, 16'h8000, 16'h7C00,
      mk_exp(4'b0100, 4'b1000, 4'b0000, 4'b0100, 0, -24, 0, 0, 11'h400, 11'h400, 11'h0, 11'h0));
    vecs[1] = mk_vec(FP8, 16'hFF08, 16'h1201, 16'h007F, 16'h8038,
      mk_exp(4'b0000, 4'b0000, 4'b0100, 4'b0000, -6, -9, 0, 0, 11'h8, 11'h8, 11'h0, 11'h8));
    vecs[2] = mk_vec(INT9, 16'hFFFF, 16'hFE00, 16'h0055, 16'h0100,
      mk_exp(4'b0010, 4'b0000, 4'b0000, 4'b1001, 0, 0, 0, 0, 11'h1FF, 11'h0, 11'h55, 11'h100));
    vecs[3] = mk_vec(FP16, 16'hFC00, 16'h7E00, 16'h0200, 16'h7BFF,
      mk_exp(4'b0000, 4'b0001, 4'b0010, 4'b0001, 0, 0, -15, 15, 11'h0, 11'h0, 11'h400, 11'h7FF));
    vecs[4] = mk_vec(FP16, 16'h0155, 16'h8001, 16'h0400, 16'hC000,
      mk_exp(4'b0000, 4'b0000, 4'b0000, 4'b1010, -16, -24, -14, 1, 11'h554, 11'h400, 11'h400, 11'h400));
    vecs[5] = mk_vec(FP8, 16'h0078, 16'hCDFF, 16'h0080, 16'hAB04,
      mk_exp(4'b0100, 4'b0000, 4'b0010, 4'b0110, 8, 0, 0, -7, 11'h8, 11'h0, 11'h0, 11'h8));
    vecs[6] = mk_vec(FP8, 16'h0002, 16'h007E, 16'h0087, 16'h0000,
      mk_exp(4'b1000, 4'b0000, 4'b0000, 4'b0100, -8, 8, -7, 0, 11'h8, 11'hE, 11'hE, 11'h0));
    vecs[7] = mk_vec(INT9, 16'h0001, 16'h00FF, 16'h0180, 16'h01FE,
      mk_exp(4'b0000, 4'b0000, 4'b0000, 4'b1100, 0, 0, 0, 0, 11'h1, 11'hFF, 11'h180, 11'h1FE));
    vecs[8] = mk_vec(FP16, 16'h83FF, 16'h0001, 16'h3C00, 16'h0000,
      mk_exp(4'b1000, 4'b0000, 4'b0000, 4'b0001, -15, -24, 0, 0, 11'h7FE, 11'h400, 11'h400, 11'h0));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 96'(o_valid), 96'd0);
    check("reset_ready", 96'(o_ready), 96'd1);
    check("reset_out", 96'(out_main), 96'd0);
    check("reset_flush_dut_ready", 96'(f_ready), 96'd1);

    // two-cycle latency from accept to o_valid
    send_beat(0);
    check("lat_cycle0", 96'(o_valid), 96'd0);
    idle();
    @(negedge clk);
    check("lat_cycle1", 96'(o_valid), 96'd0);
    @(negedge clk);
    check("lat_cycle2", 96'(o_valid), 96'd1);
    drain();

    // whole table back to back, downstream always ready
    for (int i = 0; i < 9; i++) send_beat(i);
    idle();
    drain();

    // back to back with i_ready 1,0,0,1 then random back-pressure
    for (int mode = 1; mode <= 2; mode++) begin
      rdy_mode = mode;
      for (int r = 0; r < 3; r++)
        for (int i = 0; i < 9; i++) send_beat(i);
      idle();
      drain();
    end
    rdy_mode = 0;

    // subnormal flush instance
    send_beat(8);
    idle();
    begin
      int n;
      n = 0;
      while (!f_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("flush_sub", 96'(out_f), 96'(mk_exp(4'b1011, 4'b0000, 4'b0000, 4'b0001, 0, 0, 0, 0,
                                             11'h0, 11'h0, 11'h400, 11'h0)));
    drain();

    // reset with both stages full
    rdy_mode = 3;
    @(posedge clk);
    send_beat(2);
    send_beat(1);
    idle();
    @(negedge clk);
    check("full_ready_low", 96'(o_ready), 96'd0);
    check("full_valid", 96'(o_valid), 96'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_full_valid", 96'(o_valid), 96'd0);
    check("rst_full_ready", 96'(o_ready), 96'd1);
    check("rst_full_out", 96'(out_main), 96'd0);
    rdy_mode = 0;
    send_beat(3);
    idle();
    drain();
    send_beat(4);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
